pwm_fader: RTL and testbench
============================

# pwm_fader

Upstream sequencer for the 8-channel `pwm` core. Holds per-channel target duty and ramp rate from the host bus, steps each channel's live threshold one LSB at a time toward its target, and emits the resulting register writes on `pwm`'s `addr`/`data`/`we` port, one per cycle. Host writes to the clock-shift registers are forwarded to `pwm` with priority. Outputs connect directly to `pwm.addr`, `pwm.data` and `pwm.we`.

## Interface
- `NCH`, 8: channel count. Fixed at 8 to match `pwm`.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_addr` in 5: host register select.
  - 0x00–0x07: target threshold for ch n.
  - 0x08–0x0F: shift for ch n, passed through to `pwm`.
  - 0x10–0x17: step period for ch n.
  - 0x18–0x1F: ignored.
- `cfg_data` in 8: host write data.
- `cfg_we` in 1: host write strobe, one write per cycle.
- `pwm_addr` out 4: to `pwm.addr`.
- `pwm_data` out 8: to `pwm.data`.
- `pwm_we` out 1: to `pwm.we`.
- `ramping` out 8: bit n high while `cur[n] != tgt[n]` or ch n has an unsent update.

## Operation
Per-channel state, all 8-bit: `cur` (live threshold), `tgt`, `per`, `tick`. Plus a 1-bit `pend` per channel.

Host writes:
- Target write sets `tgt[n]`. It does not touch `cur`, `tick` or the period.
- Period write sets `per[n]` and also loads `tick[n] <= cfg_data`.
- Shift write loads a single-entry passthrough slot: `{1, n}` / `{3'b0, cfg_data[4:0]}`. Bits 7:5 are zeroed.

Stepping, each cycle, per channel:
- If `tick == 0`:
  - `tick <= per`.
  - If `cur < tgt`, `cur <= cur + 1` and `pend` is set.
  - If `cur > tgt`, `cur <= cur - 1` and `pend` is set.
  - If equal, no change.
- Otherwise `tick <= tick - 1`.
- Step cadence is `per + 1` cycles. `per = 0` steps every cycle.
- `cur` never wraps; it stops at `tgt`.
- A target write landing on a step cycle: the step uses the old `tgt`, and the new `tgt` applies from the next cycle.
- A target change mid-ramp can reverse direction. No overshoot.

Output scheduling, one write per cycle:
- The passthrough slot has priority. Otherwise the lowest-index pending channel after `rr_ptr` (round-robin) is granted.
- Granted channel: outputs `pwm_addr = {0, n}`, `pwm_data = cur[n]`. Its `pend` is cleared and `rr_ptr <= n`.
- If the same channel steps again in its grant cycle, the step wins and `pend` stays set.
- Repeat steps before a grant coalesce. Only the newest `cur` is sent. A ramp may therefore skip intermediate values under contention, but the final value is always delivered.
- The passthrough slot is empty whenever it is consumed. A shift write arriving in the same cycle the slot drains refills it.
- `pwm_we` is low on idle cycles. `pwm_addr`/`pwm_data` hold their last values when idle.

## Timing
- All outputs registered.
- Reset state:
  - All internal state is cleared: `cur`, `tgt`, `per`, `tick`, `pend`, `rr_ptr`.
  - Passthrough slot is emptied.
  - Outputs: `pwm_we = 0`, `pwm_addr = 0`, `pwm_data = 0`, `ramping = 0`.
  - This state matches `pwm`'s reset thresholds, so no resync write is needed.
- Shift passthrough latency: `cfg_we` at edge N gives `pwm_we` high after edge N+1.
- Step latency, uncontended: a step at edge N gives `pwm_we` after edge N+1.
- Worst-case write latency for a channel:
  - up to 8 cycles with 8 channels pending and no shift traffic;
  - a continuous shift-write stream starves channels. This is accepted, and the host must not do it.
- Reset mid-ramp: the write in flight is dropped, and `pwm_we` is low the cycle after `rst`.

## Structure
- Shared `pwm_pkg`:
  - address-map constants `ADDR_TGT = 2'b00`, `ADDR_SHIFT = 2'b01`, `ADDR_PER = 2'b10`;
  - `NCH`, `THRESH_W = 8`, `SHIFT_W = 5`.
  - The same constants are reused by `pwm`'s address decode.
- Sub-module `pwm_fader_ch`, instantiated 8×: holds `cur`/`tgt`/`per`/`tick`/`pend` and the step logic. It exposes `pend`, `cur` and a `grant` input.
- Arbiter and passthrough slot live in the top level.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0, `pwm_we` low for 20 idle cycles.
- Ramp: period write ch2 = 2, then target ch2 = 4 → four `pwm_we` pulses with addr 0x2, data 1, 2, 3, 4, spaced 3 cycles apart, then `ramping[2]` falls. Checker uses a `pwm` model and confirms threshold[2] = 4.
- Passthrough priority: shift write `cfg_addr = 0x0A`, data 0xF3, issued during the ch2 ramp → next cycle addr 0xA, data 0x13; the ch2 write is delayed exactly 1 cycle.
- Contention: all 8 channels at period 0, targets 0→0x10 written together → writes rotate 0..7 round-robin; every channel's final value 0x10 is delivered; no channel is granted twice within any 8-cycle window.
- Reversal: ch5 ramping 0→0x80 at period 0, target set to 0x10 when `cur` = 0x20 → `cur` descends monotonically to 0x10; no value exceeds 0x21.
- Reset mid-ramp: assert `rst` while ch1 is at `cur` = 0x40 → `pwm_we` low the next cycle, `cur`/`ramping` = 0, no writes until reconfigured.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the pwm core and its upstream fader: address map,
// channel count, field widths and the shift passthrough slot layout.
package pwm_pkg;
  localparam int NCH      = 8;
  localparam int CH_W     = $clog2(NCH);
  localparam int THRESH_W = 8;
  localparam int SHIFT_W  = 5;

  // cfg_addr[4:3] selects the register bank, cfg_addr[2:0] the channel
  localparam logic [1:0] ADDR_TGT   = 2'b00;
  localparam logic [1:0] ADDR_SHIFT = 2'b01;
  localparam logic [1:0] ADDR_PER   = 2'b10;

  typedef struct packed {
    logic               vld;
    logic [CH_W-1:0]    ch;
    logic [SHIFT_W-1:0] sh;
  } slot_t;
endpackage

// File: rtl/pwm_fader_ch.sv
// One fader channel: target/period registers, step timer, and the live
// threshold that walks one LSB per step toward the target.
module pwm_fader_ch
  import pwm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                tgt_we,
  input  logic                per_we,
  input  logic [THRESH_W-1:0] wdata,
  input  logic                grant,
  output logic [THRESH_W-1:0] cur,
  output logic                pend,
  output logic                ramp
);
  logic [THRESH_W-1:0] tgt, per, tick;
  logic [THRESH_W-1:0] cur_n, tgt_n, per_n, tick_n;
  logic                pend_n, step;

  always_comb begin
    step   = (tick == '0) && (cur != tgt);
    cur_n  = cur;
    if (tick == '0) begin
      // compares against the old target; a same-cycle target write lands next cycle
      if (cur < tgt)      cur_n = cur + 1'b1;
      else if (cur > tgt) cur_n = cur - 1'b1;
    end
    tgt_n  = tgt_we ? wdata : tgt;
    per_n  = per_we ? wdata : per;
    if (per_we)            tick_n = wdata;
    else if (tick == '0)   tick_n = per;
    else                   tick_n = tick - 1'b1;
    // a step in the grant cycle keeps pend so the newer value still goes out
    pend_n = step | (pend & ~grant);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= '0;
      tgt  <= '0;
      per  <= '0;
      tick <= '0;
      pend <= 1'b0;
      ramp <= 1'b0;
    end else begin
      cur  <= cur_n;
      tgt  <= tgt_n;
      per  <= per_n;
      tick <= tick_n;
      pend <= pend_n;
      ramp <= (cur_n != tgt_n) | pend_n;
    end
  end
endmodule

// File: rtl/pwm_fader.sv
// Fader front end for the 8-channel pwm core: host decode, per-channel
// ramps, and a one-write-per-cycle scheduler with shift passthrough priority.
module pwm_fader
  import pwm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          cfg_addr,
  input  logic [7:0]          cfg_data,
  input  logic                cfg_we,
  output logic [3:0]          pwm_addr,
  output logic [7:0]          pwm_data,
  output logic                pwm_we,
  output logic [NCH-1:0]      ramping
);
  logic [1:0]                     region;
  logic [CH_W-1:0]                ch;
  logic [NCH-1:0]                 tgt_we, per_we, pend, grant;
  logic [NCH-1:0][THRESH_W-1:0]   cur;
  logic [CH_W-1:0]                rr_ptr, gnt_idx;
  logic                           found, shift_we;
  slot_t                          slot;

  assign region   = cfg_addr[4:3];
  assign ch       = cfg_addr[2:0];
  assign shift_we = cfg_we && (region == ADDR_SHIFT);
  assign tgt_we   = (cfg_we && region == ADDR_TGT) ? (NCH'(1) << ch) : '0;
  assign per_we   = (cfg_we && region == ADDR_PER) ? (NCH'(1) << ch) : '0;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_fader_ch u_ch (
      .clk    (clk),
      .rst    (rst),
      .tgt_we (tgt_we[g]),
      .per_we (per_we[g]),
      .wdata  (cfg_data),
      .grant  (grant[g]),
      .cur    (cur[g]),
      .pend   (pend[g]),
      .ramp   (ramping[g])
    );
  end

  // round-robin search starts just past the last granted channel
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_ptr;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && pend[rr_ptr + CH_W'(i)]) begin
        found   = 1'b1;
        gnt_idx = rr_ptr + CH_W'(i);
      end
    end
    grant = '0;
    if (found && !slot.vld) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      rr_ptr   <= '0;
      pwm_we   <= 1'b0;
      pwm_addr <= '0;
      pwm_data <= '0;
    end else begin
      pwm_we <= 1'b0;
      if (slot.vld) begin
        pwm_we   <= 1'b1;
        pwm_addr <= {1'b1, slot.ch};
        pwm_data <= {{(THRESH_W-SHIFT_W){1'b0}}, slot.sh};
      end else if (found) begin
        pwm_we   <= 1'b1;
        pwm_addr <= {1'b0, gnt_idx};
        pwm_data <= cur[gnt_idx];
        rr_ptr   <= gnt_idx;
      end
      // the slot always drains when full, so it only holds a same-cycle refill
      slot.vld <= shift_we;
      if (shift_we) begin
        slot.ch <= ch;
        slot.sh <= cfg_data[SHIFT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader: logs every pwm write with its cycle stamp
// into a queue and a small pwm register model, then checks per scenario.
module tb_pwm_fader;
  logic       clk, rst, cfg_we, pwm_we;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_data, pwm_data, ramping;
  logic [3:0] pwm_addr;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] thr[8];
  logic [4:0] shf[8];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  pwm_fader dut (
    .clk(clk), .rst(rst), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we),
    .pwm_addr(pwm_addr), .pwm_data(pwm_data), .pwm_we(pwm_we), .ramping(ramping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pwm register model plus write log
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin thr[i] = '0; shf[i] = '0; end
    end else if (pwm_we) begin
      wq.push_back('{pwm_addr, pwm_data, cyc});
      if (!pwm_addr[3]) thr[pwm_addr[2:0]] = pwm_data;
      else              shf[pwm_addr[2:0]] = pwm_data[4:0];
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_data = d; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0;
    step(); step();
    rst = 1'b0;
    wq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pwm_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", pwm_we); end
    checks++; if (pwm_addr !== 4'h0) begin errors++; $display("FAIL reset_addr got %h want 0", pwm_addr); end
    checks++; if (pwm_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", pwm_data); end
    checks++; if (ramping !== 8'h00) begin errors++; $display("FAIL reset_ramping got %h want 00", ramping); end
    for (int i = 0; i < 20; i++) step();
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL reset_idle writes got %0d want 0", wq.size()); end
  endtask

  task automatic test_ramp();
    int t0, k;
    do_reset();
    cfg(5'h12, 8'd2);
    cfg(5'h02, 8'd4);
    t0 = cyc;
    checks++; if (ramping[2] !== 1'b1) begin errors++; $display("FAIL ramp_start ramping got %h want bit2", ramping); end
    k = 0;
    while (wq.size() < 4 && k < 100) begin step(); k++; end
    checks++;
    if (wq.size() < 4) begin errors++; $display("FAIL ramp_timeout writes got %0d want 4", wq.size()); end
    else begin
      checks++; if (wq[0].c != t0 + 3) begin errors++; $display("FAIL ramp_latency got %0d want %0d", wq[0].c - t0, 3); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i].a !== 4'h2 || wq[i].d !== 8'(i + 1)) begin
          errors++; $display("FAIL ramp_wr%0d got %h/%h want 2/%h", i, wq[i].a, wq[i].d, i + 1);
        end
        if (i > 0) begin
          checks++;
          if (wq[i].c - wq[i-1].c != 3) begin errors++; $display("FAIL ramp_gap%0d got %0d want 3", i, wq[i].c - wq[i-1].c); end
        end
      end
    end
    k = 0;
    while (ramping[2] && k < 20) begin step(); k++; end
    checks++; if (ramping !== 8'h00) begin errors++; $display("FAIL ramp_done ramping got %h want 00", ramping); end
    checks++; if (thr[2] !== 8'd4) begin errors++; $display("FAIL ramp_model thr2 got %h want 04", thr[2]); end
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL ramp_count got %0d want 4", wq.size()); end
  endtask

  task automatic test_passthrough();
    int t0, k;
    do_reset();
    cfg(5'h12, 8'd2);
    cfg(5'h02, 8'd4);
    t0 = cyc;
    k = 0;
    while (wq.size() < 1 && k < 20) begin step(); k++; end
    step();
    cfg(5'h0A, 8'hF3);
    k = 0;
    while (wq.size() < 5 && k < 40) begin step(); k++; end
    checks++;
    if (wq.size() < 5) begin errors++; $display("FAIL pass_timeout writes got %0d want 5", wq.size()); end
    else begin
      checks++;
      if (wq[1].a !== 4'hA || wq[1].d !== 8'h13 || wq[1].c != t0 + 6) begin
        errors++; $display("FAIL pass_shift got %h/%h@%0d want a/13@%0d", wq[1].a, wq[1].d, wq[1].c - t0, 6);
      end
      checks++;
      if (wq[2].a !== 4'h2 || wq[2].d !== 8'd2 || wq[2].c != t0 + 7) begin
        errors++; $display("FAIL pass_delayed got %h/%h@%0d want 2/02@%0d", wq[2].a, wq[2].d, wq[2].c - t0, 7);
      end
      checks++;
      if (wq[3].d !== 8'd3 || wq[3].c != t0 + 9 || wq[4].d !== 8'd4 || wq[4].c != t0 + 12) begin
        errors++; $display("FAIL pass_resume got %h@%0d %h@%0d want 03@9 04@12", wq[3].d, wq[3].c - t0, wq[4].d, wq[4].c - t0);
      end
    end
    checks++; if (shf[2] !== 5'h13) begin errors++; $display("FAIL pass_model shf2 got %h want 13", shf[2]); end
  endtask

  task automatic test_contention();
    int k;
    logic [7:0] dv;
    do_reset();
    for (int n = 0; n < 8; n++) cfg(5'(n), 8'h10);
    k = 0;
    while (wq.size() < 24 && k < 100) begin step(); k++; end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (wq.size() != 24) begin errors++; $display("FAIL cont_count got %0d want 24", wq.size()); end
    else begin
      for (int i = 0; i < 24; i++) begin
        dv = (i < 8) ? 8'h01 : (i < 16) ? 8'h09 : 8'h10;
        checks++;
        if (wq[i].a !== 4'(i % 8) || wq[i].d !== dv || (i > 0 && wq[i].c != wq[i-1].c + 1)) begin
          errors++; $display("FAIL cont_wr%0d got %h/%h want %h/%h", i, wq[i].a, wq[i].d, i % 8, dv);
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      checks++; if (thr[n] !== 8'h10) begin errors++; $display("FAIL cont_model thr%0d got %h want 10", n, thr[n]); end
    end
    checks++; if (ramping !== 8'h00) begin errors++; $display("FAIL cont_done ramping got %h want 00", ramping); end
  endtask

  task automatic test_reversal();
    int k, pk;
    logic [7:0] mx;
    logic mono;
    do_reset();
    cfg(5'h05, 8'h80);
    k = 0;
    while (!(wq.size() > 0 && wq[$].d == 8'h1F) && k < 100) begin step(); k++; end
    cfg(5'h05, 8'h10);
    k = 0;
    while (ramping[5] && k < 200) begin step(); k++; end
    checks++; if (ramping[5] !== 1'b0) begin errors++; $display("FAIL rev_timeout ramping got %h want 00", ramping); end
    mx = '0; pk = 0;
    foreach (wq[i]) if (wq[i].d > mx) begin mx = wq[i].d; pk = i; end
    mono = 1'b1;
    for (int i = pk + 1; i < wq.size(); i++) if (wq[i].d > wq[i-1].d) mono = 1'b0;
    checks++; if (mx !== 8'h21) begin errors++; $display("FAIL rev_peak got %h want 21", mx); end
    checks++; if (mono !== 1'b1) begin errors++; $display("FAIL rev_monotonic got %b want 1", mono); end
    checks++; if (wq.size() != 50) begin errors++; $display("FAIL rev_count got %0d want 50", wq.size()); end
    checks++; if (thr[5] !== 8'h10) begin errors++; $display("FAIL rev_model thr5 got %h want 10", thr[5]); end
  endtask

  task automatic test_reset_mid();
    int k, n;
    do_reset();
    cfg(5'h01, 8'hFF);
    k = 0;
    while (!(wq.size() > 0 && wq[$].d == 8'h3F) && k < 100) begin step(); k++; end
    checks++; if (k >= 100) begin errors++; $display("FAIL mid_timeout got %0d cycles want <100", k); end
    rst = 1'b1;
    step();
    checks++; if (pwm_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", pwm_we); end
    checks++; if (ramping !== 8'h00 || pwm_data !== 8'h00) begin errors++; $display("FAIL mid_state ramping/data got %h/%h want 00/00", ramping, pwm_data); end
    rst = 1'b0;
    n = wq.size();
    for (int i = 0; i < 20; i++) step();
    checks++; if (wq.size() != n) begin errors++; $display("FAIL mid_quiet writes got %0d want 0", wq.size() - n); end
    cfg(5'h01, 8'h01);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (wq.size() != n + 1 || wq[$].d !== 8'h01) begin
      errors++; $display("FAIL mid_restart writes %0d last %h want 1 write of 01", wq.size() - n, wq[$].d);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    test_reset();
    test_ramp();
    test_passthrough();
    test_contention();
    test_reversal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
